riscv_issue_queue: RTL and testbench

- Consumer-side endpoint of the single-wide valid/ready instruction stream. It is the receiving end of the fetch-path skid buffer.
- Accepts one entry per cycle into a small circular buffer.
- Presents the two oldest entries in parallel to the dual-issue decode stage, which retires 0, 1 or 2 of them per cycle.
- Flushed together with the front end on redirect.

---
 rtl/riscv_issue_queue_pkg.sv | 14 +
 rtl/riscv_issue_queue.sv | 94 +++++++++
 tb/tb_riscv_issue_queue.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_issue_queue_pkg.sv
// Core pipeline constants shared between the issue queue and the dual-issue decoder.
// These are the pop-count values decode drives to say how many entries it retired this cycle.
package riscv_issue_queue_pkg;

    localparam logic [1:0] POP_NONE = 2'd0;
    localparam logic [1:0] POP_ONE  = 2'd1;
    localparam logic [1:0] POP_TWO  = 2'd2;

    // Decode may drive 3 on a glitchy path; anything above two retires two.
    function automatic logic [1:0] pop_saturate(input logic [1:0] raw);
        return (raw > POP_TWO) ? POP_TWO : raw;
    endfunction

endpackage

// File: rtl/riscv_issue_queue.sv
// Instruction issue queue: single-wide valid/ready input from the fetch skid buffer,
// the two oldest entries presented in parallel to dual-issue decode, and a flush
// that empties the queue together with the rest of the front end.
module riscv_issue_queue
    import riscv_issue_queue_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  srst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic                  out0_valid,
    output logic [DATA_WIDTH-1:0] out0_data,
    output logic                  out1_valid,
    output logic [DATA_WIDTH-1:0] out1_data,
    input  logic [1:0]            pop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr_plus1;
    logic [CNT_W-1:0]      count;

    logic                  push;
    logic [1:0]            req_pop;
    logic [1:0]            eff_pop;
    logic                  over_pop;

    // Ready comes only from the registered count, so a same-cycle pop never opens a slot
    // while full; flush suppresses the push and the pop, and over-pops clamp to occupancy.
    always_comb begin
        data_in_ready = (count != CNT_W'(DEPTH));
        push          = data_in_valid & data_in_ready & ~flush;
        req_pop       = pop_saturate(pop_cnt);
        over_pop      = srst_n & ~flush & (CNT_W'(req_pop) > count);
        eff_pop       = POP_NONE;
        if (!flush) begin
            if (CNT_W'(req_pop) > count) begin
                eff_pop = count[1:0];
            end else begin
                eff_pop = req_pop;
            end
        end
    end

    // Pointer and occupancy bookkeeping; reset and flush both return to empty.
    always_ff @(posedge clk) begin
        if (!srst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr + PTR_W'(eff_pop);
            count  <= count + CNT_W'(push) - CNT_W'(eff_pop);
        end
    end

    // Entry storage carries no reset: contents are only looked at while counted as valid.
    always_ff @(posedge clk) begin
        if (srst_n && push) begin
            storage[wr_ptr] <= data_in;
        end
    end

    // Present the two oldest entries straight from storage; the second index wraps on its own.
    always_comb begin
        rd_ptr_plus1 = rd_ptr + PTR_W'(1);
        out0_valid   = (count >= CNT_W'(1));
        out1_valid   = (count >= CNT_W'(2));
        out0_data    = storage[rd_ptr];
        out1_data    = storage[rd_ptr_plus1];
    end

`ifndef SYNTHESIS
    // Decode asking for more entries than are present is a protocol slip upstream of us;
    // the queue survives it by clamping, but it should be visible in simulation.
    always @(posedge clk) begin
        assert (!over_pop)
        else $warning("riscv_issue_queue: pop_cnt exceeds occupancy, pop clamped");
    end
`endif

endmodule

// File: tb/tb_riscv_issue_queue.sv
// Scoreboard bench for riscv_issue_queue: directed vectors queue their expected entries,
// a negedge monitor checks every consumed entry in FIFO order, and directed checks
// cover ready/valid flags and visible data after each step.
module tb_riscv_issue_queue;

    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 4;

    logic                  clk;
    logic                  srst_n;
    logic                  flush;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_valid;
    logic                  data_in_ready;
    logic                  out0_valid;
    logic [DATA_WIDTH-1:0] out0_data;
    logic                  out1_valid;
    logic [DATA_WIDTH-1:0] out1_data;
    logic [1:0]            pop_cnt;

    logic [DATA_WIDTH-1:0] exp_q [$];
    int                    checks;
    int                    errors;
    int                    mon_n;
    bit                    saw_over_pop;

    riscv_issue_queue #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .srst_n       (srst_n),
        .flush        (flush),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .out0_valid   (out0_valid),
        .out0_data    (out0_data),
        .out1_valid   (out1_valid),
        .out1_data    (out1_data),
        .pop_cnt      (pop_cnt)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so a stuck run still reports and ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one consumed entry against the oldest expected entry.
    task automatic scoreboardPop(input string name, input logic [DATA_WIDTH-1:0] actual);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%08h required=<no entry expected>", name, actual);
        end else begin
            logic [DATA_WIDTH-1:0] want;
            want = exp_q.pop_front();
            if (actual !== want) begin
                errors++;
                $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, want);
            end
        end
    endtask

    // Monitor: at each negedge, whatever decode retires this cycle must match the scoreboard.
    always @(negedge clk) begin
        if (srst_n === 1'b1 && flush === 1'b0) begin
            mon_n = (pop_cnt == 2'd3) ? 2 : int'(pop_cnt);
            if (dut.over_pop === 1'b1) saw_over_pop = 1'b1;
            if (mon_n >= 1 && out0_valid === 1'b1) scoreboardPop("out0_order", out0_data);
            if (mon_n >= 2 && out1_valid === 1'b1) scoreboardPop("out1_order", out1_data);
        end
    end

    // Drive one cycle of inputs, record the expected push or flush, and step past the edge.
    task automatic applyStimulus(input logic vld, input logic [DATA_WIDTH-1:0] dat,
                                 input logic [1:0] pop, input logic fl, input bit accepted);
        data_in_valid = vld;
        data_in       = dat;
        pop_cnt       = pop;
        flush         = fl;
        if (fl) exp_q.delete();
        if (accepted) exp_q.push_back(dat);
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        pop_cnt       = 2'd0;
        flush         = 1'b0;
    endtask

    // Check flags and, where valid, the visible entries.
    task automatic checkOutput(input string name, input logic exp_ready,
                               input logic exp_v0, input logic [DATA_WIDTH-1:0] exp_d0,
                               input logic exp_v1, input logic [DATA_WIDTH-1:0] exp_d1);
        checks++;
        if (data_in_ready !== exp_ready || out0_valid !== exp_v0 || out1_valid !== exp_v1) begin
            errors++;
            $display("[TB] FAIL %s flags: actual rdy=%b v0=%b v1=%b required rdy=%b v0=%b v1=%b",
                     name, data_in_ready, out0_valid, out1_valid, exp_ready, exp_v0, exp_v1);
        end
        if (exp_v0) begin
            checks++;
            if (out0_data !== exp_d0) begin
                errors++;
                $display("[TB] FAIL %s out0_data: actual=0x%08h required=0x%08h", name, out0_data, exp_d0);
            end
        end
        if (exp_v1) begin
            checks++;
            if (out1_data !== exp_d1) begin
                errors++;
                $display("[TB] FAIL %s out1_data: actual=0x%08h required=0x%08h", name, out1_data, exp_d1);
            end
        end
    endtask

    // Single-bit comparison helper for bench-side flags.
    task automatic checkBit(input string name, input logic actual, input logic required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual=%b required=%b", name, actual, required);
        end
    endtask

    // Directed sequence.
    initial begin
        checks        = 0;
        errors        = 0;
        saw_over_pop  = 1'b0;
        srst_n        = 1'b0;
        flush         = 1'b0;
        data_in       = '0;
        data_in_valid = 1'b0;
        pop_cnt       = 2'd0;

        // Reset held for two cycles, then released.
        repeat (2) @(posedge clk);
        #1;
        srst_n = 1'b1;
        checkOutput("reset", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        applyStimulus(1'b1, 32'h0000_0013, 2'd0, 1'b0, 1'b1);
        checkOutput("first_push", 1'b1, 1'b1, 32'h0000_0013, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 2'd1, 1'b0, 1'b0);
        checkOutput("first_pop", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // Fill to DEPTH with no pops.
        applyStimulus(1'b1, 32'hA0, 2'd0, 1'b0, 1'b1);
        checkOutput("fill_1", 1'b1, 1'b1, 32'hA0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'hA1, 2'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hA2, 2'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hA3, 2'd0, 1'b0, 1'b1);
        checkOutput("full", 1'b0, 1'b1, 32'hA0, 1'b1, 32'hA1);
        applyStimulus(1'b1, 32'hA4, 2'd0, 1'b0, 1'b0);
        checkOutput("full_reject", 1'b0, 1'b1, 32'hA0, 1'b1, 32'hA1);

        // Dual pop while full with upstream still valid: the push is refused.
        applyStimulus(1'b1, 32'hA4, 2'd2, 1'b0, 1'b0);
        checkOutput("dual_pop", 1'b1, 1'b1, 32'hA2, 1'b1, 32'hA3);
        applyStimulus(1'b1, 32'hA4, 2'd1, 1'b0, 1'b1);
        checkOutput("wrap_push_a4", 1'b1, 1'b1, 32'hA3, 1'b1, 32'hA4);
        applyStimulus(1'b1, 32'hA5, 2'd1, 1'b0, 1'b1);
        checkOutput("wrap_push_a5", 1'b1, 1'b1, 32'hA4, 1'b1, 32'hA5);
        applyStimulus(1'b0, 32'h0, 2'd3, 1'b0, 1'b0);
        checkOutput("pop3_drain", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // Steady stream: one in, one out, occupancy stays at one.
        applyStimulus(1'b1, 32'h100, 2'd0, 1'b0, 1'b1);
        for (int i = 1; i < 16; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(i), 2'd1, 1'b0, 1'b1);
            checkOutput("stream", 1'b1, 1'b1, 32'h100 + 32'(i), 1'b0, 32'h0);
        end
        applyStimulus(1'b0, 32'h0, 2'd1, 1'b0, 1'b0);
        checkOutput("stream_drain", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkBit("no_over_pop_yet", saw_over_pop, 1'b0);

        // Over-pop: two requested, one present.
        applyStimulus(1'b1, 32'h55, 2'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 2'd2, 1'b0, 1'b0);
        checkOutput("over_pop", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkBit("over_pop_flagged", saw_over_pop, 1'b1);
        applyStimulus(1'b1, 32'h56, 2'd0, 1'b0, 1'b1);
        checkOutput("after_over_pop", 1'b1, 1'b1, 32'h56, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 2'd1, 1'b0, 1'b0);

        // Flush with a push and a pop in the same cycle.
        applyStimulus(1'b1, 32'h61, 2'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h62, 2'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h63, 2'd0, 1'b0, 1'b1);
        checkOutput("pre_flush", 1'b1, 1'b1, 32'h61, 1'b1, 32'h62);
        applyStimulus(1'b1, 32'h77, 2'd1, 1'b1, 1'b0);
        checkOutput("flush", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h88, 2'd0, 1'b0, 1'b1);
        checkOutput("post_flush", 1'b1, 1'b1, 32'h88, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 2'd1, 1'b0, 1'b0);

        // Reset in the middle of traffic behaves like flush.
        applyStimulus(1'b1, 32'h91, 2'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h92, 2'd0, 1'b0, 1'b1);
        srst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        srst_n = 1'b1;
        checkOutput("mid_reset", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h93, 2'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h94, 2'd0, 1'b0, 1'b1);
        checkOutput("post_reset", 1'b1, 1'b1, 32'h93, 1'b1, 32'h94);
        applyStimulus(1'b0, 32'h0, 2'd2, 1'b0, 1'b0);

        // Everything expected must have been seen.
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drained: actual=%0d left required=0", exp_q.size());
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
